// File: rtl/memory_interface.sv
// Multi-cycle memory access unit: latches a read/write request, holds wait_ for LATENCY cycles, commits on the last.
// Latency LATENCY+1 cycles per access; wait_ is the controller backpressure, strobes are ignored while BUSY.
module memory_interface #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wait_,
    output logic              err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                rdata_valid_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    logic req_one, req_both, commit;

    assign req_one  = mem_rd ^ mem_wr;
    assign req_both = mem_rd & mem_wr;
    assign commit   = (state_q == BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                // Conflicting strobes are rejected without touching the operand latches.
                if (req_one) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    op_wr_d = mem_wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_ = 1'b0;
        case (state_q)
            IDLE:    wait_ = req_one;
            BUSY:    wait_ = (cnt_q != 4'd0);
            default: wait_ = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= commit && !op_wr_q;
            err_q         <= (state_q == IDLE) && req_both;
            if (commit && !op_wr_q) begin
                rdata_q <= mem[addr_q];
            end
        end
    end

    // RAM is deliberately not reset; a reset mid-access must drop the pending write.
    always_ff @(posedge clk) begin
        if (!reset && commit && op_wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_memory_interface.sv
// Scoreboard bench for memory_interface: LATENCY=2 main instance plus a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_memory_interface;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdata_valid, wait_, err;

    logic        mem_rd1, mem_wr1;
    logic [11:0] addr1;
    logic [15:0] wdata1;
    logic [15:0] rdata1;
    logic        rdata_valid1, wait1, err1;

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] model [int];
    logic [15:0] model1 [int];
    logic [15:0] exp_q [$];
    logic [15:0] exp1_q [$];

    always #5 clk = ~clk;

    memory_interface #(.ADDR_W(12), .DATA_W(16), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .wait_(wait_), .err(err)
    );

    memory_interface #(.ADDR_W(12), .DATA_W(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1), .rdata_valid(rdata_valid1),
        .wait_(wait1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
            else                   chk("rd_data", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
        end
        if (rdata_valid1 === 1'b1) begin
            if (exp1_q.size() == 0) chk("rd1_spurious", 32'd1, 32'd0);
            else                    chk("rd1_data", {16'd0, rdata1}, {16'd0, exp1_q.pop_front()});
        end
    end

    // Entered #1 after a rising edge; returns #1 after the commit edge with strobes low.
    task automatic access(input logic wr, input logic [11:0] a, input logic [15:0] d,
                          input logic hold, input string tag);
        mem_rd = !wr;
        mem_wr = wr;
        addr   = a;
        wdata  = d;
        if (wr) model[int'(a)] = d;
        else    exp_q.push_back(model[int'(a)]);
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            chk({tag, "_wait"}, {31'd0, wait_}, {31'd0, (i < LAT)});
            @(posedge clk);
            #1;
            if (!hold) begin
                mem_rd = 1'b0;
                mem_wr = 1'b0;
                addr   = ~a;
                wdata  = ~d;
            end
        end
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic access1(input logic wr, input logic [11:0] a, input logic [15:0] d,
                           input string tag);
        mem_rd1 = !wr;
        mem_wr1 = wr;
        addr1   = a;
        wdata1  = d;
        if (wr) model1[int'(a)] = d;
        else    exp1_q.push_back(model1[int'(a)]);
        for (int i = 0; i <= 1; i++) begin
            @(negedge clk);
            chk({tag, "_wait"}, {31'd0, wait1}, {31'd0, (i < 1)});
            @(posedge clk);
            #1;
        end
        mem_rd1 = 1'b0;
        mem_wr1 = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        mem_rd  = 1'b0; mem_wr  = 1'b0; addr  = '0; wdata  = '0;
        mem_rd1 = 1'b0; mem_wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wait",  {31'd0, wait_},       32'd0);
        chk("rst_rdata", {16'd0, rdata},       32'd0);
        chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_err",   {31'd0, err},         32'd0);
        tick();
        reset = 1'b0;

        access(1'b1, 12'h0A5, 16'h1234, 1'b1, "wr_a5");
        access(1'b0, 12'h0A5, 16'h0000, 1'b1, "rd_a5");

        access(1'b1, 12'hFFF, 16'hBEEF, 1'b1, "wr_fff");
        access(1'b0, 12'hFFF, 16'h0000, 1'b1, "rd_fff");
        access(1'b1, 12'h000, 16'h0001, 1'b1, "wr_000");
        access(1'b0, 12'h000, 16'h0000, 1'b1, "rd_000");
        access(1'b0, 12'hFFF, 16'h0000, 1'b1, "rd_fff2");

        // Illegal request: both strobes with new operands that must not land anywhere.
        mem_rd = 1'b1; mem_wr = 1'b1; addr = 12'h0A5; wdata = 16'hDEAD;
        @(negedge clk);
        chk("both_wait", {31'd0, wait_}, 32'd0);
        chk("both_err0", {31'd0, err},   32'd0);
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        chk("both_err1",  {31'd0, err},   32'd1);
        chk("both_rdata", {16'd0, rdata}, 32'h0000BEEF);
        chk("both_wait2", {31'd0, wait_}, 32'd0);
        tick();
        @(negedge clk);
        chk("both_err2", {31'd0, err}, 32'd0);
        tick();
        access(1'b0, 12'h0A5, 16'h0000, 1'b1, "rd_a5_after_err");

        // Operands and strobe change right after the request cycle.
        access(1'b1, 12'h333, 16'h4321, 1'b0, "wr_drop");
        @(negedge clk);
        chk("drop_idle", {31'd0, wait_}, 32'd0);
        tick();
        access(1'b0, 12'h333, 16'h0000, 1'b0, "rd_drop");

        access(1'b1, 12'h010, 16'h5555, 1'b1, "wr_pre");
        access(1'b0, 12'h010, 16'h0000, 1'b1, "rd_pre");
        mem_wr = 1'b1; addr = 12'h010; wdata = 16'hAAAA;
        @(negedge clk);
        chk("rst_wr_wait", {31'd0, wait_}, 32'd1);
        tick();
        mem_wr = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        @(negedge clk);
        chk("rst_mid_wait",  {31'd0, wait_}, 32'd0);
        chk("rst_mid_rdata", {16'd0, rdata}, 32'd0);
        tick();
        access(1'b0, 12'h010, 16'h0000, 1'b1, "rd_after_rst");

        access1(1'b1, 12'h7FF, 16'hC3C3, "l1_wr");
        access1(1'b0, 12'h7FF, 16'h0000, "l1_rd");
        access1(1'b1, 12'h001, 16'h0F0F, "l1_wr2");
        access1(1'b0, 12'h001, 16'h0000, "l1_rd2");

        repeat (3) tick();
        chk("sb_empty",  exp_q.size(),  32'd0);
        chk("sb1_empty", exp1_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_interface.md
# memory_interface

Multi-cycle memory access unit for the SAM CPU, sitting directly upstream of the microprogrammed controller. It consumes the memory read/write strobes decoded from the controller's control bus, performs the access against an internal word-addressed RAM with a fixed, parameterized latency, and produces the `wait_` status bit that the controller's next-state multiplexer tests while looping on a memory microinstruction. Read data is returned in a holding register for the datapath (MBR).

## Interface

Parameters:
- `ADDR_W`, 12: address width; RAM depth is 2^ADDR_W words.
- `DATA_W`, 16: word width.
- `LATENCY`, 2: wait cycles per access; legal range 1..15.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `mem_rd`  input  1  read request strobe from the control bus.
- `mem_wr`  input  1  write request strobe from the control bus.
- `addr`  input  ADDR_W  word address (from MAR).
- `wdata`  input  DATA_W  write data (from MBR).
- `rdata`  output  DATA_W  registered read data; holds until the next read commits.
- `rdata_valid`  output  1  one-cycle pulse, the cycle after a read commits.
- `wait_`  output  1  high = access in progress, controller must hold its state.
- `err`  output  1  one-cycle pulse, the cycle after an illegal request (rd and wr together).

## Operation

- States: IDLE, BUSY. Down-counter `cnt`, 4 bits.
- IDLE, exactly one of `mem_rd`/`mem_wr` high: latch `addr`, `wdata`, op; load `cnt = LATENCY-1`; go BUSY. `wait_` is high combinationally in this cycle.
- IDLE, both strobes high: no access, no latch, `wait_` = 0, `err` pulses next cycle, stay IDLE.
- IDLE, no strobe: `wait_` = 0.
- BUSY, `cnt != 0`: `wait_` = 1, decrement `cnt`.
- BUSY, `cnt == 0` (commit cycle): `wait_` = 0 so the controller advances on this edge. At the edge, a write stores the latched data at the latched address; a read loads `rdata` from RAM[latched addr]. Go IDLE.
- Strobes are ignored while BUSY. A strobe still high in the commit cycle does not start a new access. Dropping a strobe mid-access does not abort it; the latched operands complete.
- Only the latched address and data are used; changes on `addr`/`wdata` after the request cycle have no effect.
- Address is taken modulo 2^ADDR_W with no out-of-range condition. RAM contents are not reset and power up X.

## Timing

- Every access occupies exactly LATENCY+1 cycles, request cycle included. `wait_` is high for the first LATENCY cycles and low in the last.
- `rdata` and `rdata_valid` are updated on the commit edge. Read data is usable by the datapath in the cycle after the commit cycle. `rdata` is unchanged by writes and errors.
- Back-to-back accesses are allowed: a new request may be issued in the cycle right after the commit cycle. Peak throughput is one access per LATENCY+1 cycles.
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `rdata_valid` 0, `err` 0, `wait_` 0 (given no strobe).
- Reset during BUSY abandons the access. A pending write is not committed and `rdata` clears to 0. Reset overrides a same-cycle request.

## Test plan

- LATENCY=2. Write 0x1234 to 0x0A5: `wait_` = 1,1,0 over three cycles. Then read 0x0A5: `wait_` = 1,1,0, `rdata` = 0x1234 with `rdata_valid` pulse in the following cycle.
- Back-to-back: write 0xBEEF@0xFFF, then a read of 0xFFF in the next cycle returns 0xBEEF. Then write 0x0001@0x000 and read 0x000 returns 0x0001, proving no aliasing at the address extremes.
- `mem_rd` and `mem_wr` high together in IDLE: `wait_` stays 0, `err` pulses for one cycle, RAM and `rdata` are unchanged.
- Change `addr`/`wdata` and drop `mem_wr` after the request cycle: the original address and data are written, and the read-back confirms them.
- Preload 0x5555@0x010, start a write of 0xAAAA@0x010, assert `reset` in the second cycle: `wait_` = 0 and `rdata` = 0 next cycle, and a subsequent read returns 0x5555.
- LATENCY=1 build: every access is 2 cycles, with `wait_` = 1,0.
